bcd_entry_ctrl: RTL

BCD_ENTRY_CTRL -- requirements
Module: bcd_entry_ctrl

---
 rtl/bcd_entry_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bcd_entry_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_entry_ctrl
//
// Keypad-style decimal entry with on-demand BCD-to-binary conversion.
// Digits shift into a BCD entry register (newest digit in the least
// significant nibble).  On enter, the entry is copied into a shift register
// and converted one digit per cycle (acc = acc*10 + next digit), taking
// exactly NDIG cycles, after which bin is loaded and done pulses.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous active-high reset
//   key_valid  in   one-cycle pulse, key_code holds a digit keypress
//   key_code   in   4-bit digit value (0-9 legal, 10-15 ignored)
//   key_back   in   one-cycle pulse, delete the last entered digit
//   key_clear  in   one-cycle pulse, clear entry and result
//   enter      in   one-cycle pulse, start converting the current entry
//   bcd        out  entry register, least significant digit in [3:0]
//   ndigits    out  count of significant digits in bcd (0..NDIG)
//   full       out  high when ndigits == NDIG
//   bin        out  binary value of the last converted entry
//   busy       out  high while a conversion is in progress
//   done       out  one-cycle pulse when bin updates
// -----------------------------------------------------------------------------
module bcd_entry_ctrl #(
    parameter  int NDIG = 13,
    localparam int SW   = 4 * NDIG,
    localparam int NW   = $clog2(NDIG + 1),
    // Bits needed for 10**NDIG - 1: ceil(NDIG * log2(10)), 44 at the default.
    localparam int BW   = (NDIG * 3322 + 999) / 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          key_back,
    input  logic          key_clear,
    input  logic          enter,
    output logic [SW-1:0] bcd,
    output logic [NW-1:0] ndigits,
    output logic          full,
    output logic [BW-1:0] bin,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        ENTRY = 1'b0,
        CONV  = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] bcd_n;
    logic [NW-1:0] ndigits_n;
    logic [BW-1:0] bin_n;
    logic          done_n;
    logic [SW-1:0] sr, sr_n;
    logic [BW-1:0] acc, acc_n;
    logic [NW-1:0] cnt, cnt_n;
    logic [BW-1:0] acc_step;

    // acc*10 built from shifts and adds; the top nibble of sr is the next
    // (most significant remaining) digit.  Sized so legal BCD never overflows.
    assign acc_step = (acc << 3) + (acc << 1) + {{(BW - 4){1'b0}}, sr[SW-1 -: 4]};

    assign busy = (state == CONV);
    assign full = (ndigits == NW'(NDIG));

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        bcd_n     = bcd;
        ndigits_n = ndigits;
        bin_n     = bin;
        sr_n      = sr;
        acc_n     = acc;
        cnt_n     = cnt;
        done_n    = 1'b0;

        unique case (state)
            ENTRY: begin
                // Only the highest-priority input acts in a given cycle.
                if (key_clear) begin
                    bcd_n     = '0;
                    ndigits_n = '0;
                    bin_n     = '0;
                end else if (enter) begin
                    sr_n    = bcd;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = CONV;
                end else if (key_back) begin
                    if (ndigits != '0) begin
                        bcd_n     = bcd >> 4;
                        ndigits_n = ndigits - 1'b1;
                    end
                end else if (key_valid && (key_code <= 4'd9)) begin
                    // Drop digits when full, and swallow leading zeros so
                    // ndigits counts significant digits only.
                    if (!full && !((key_code == 4'd0) && (ndigits == '0))) begin
                        bcd_n     = {bcd[SW-5:0], key_code};
                        ndigits_n = ndigits + 1'b1;
                    end
                end
            end

            CONV: begin
                // Keys are ignored here; nothing is queued for later.
                acc_n = acc_step;
                sr_n  = sr << 4;
                cnt_n = cnt + 1'b1;
                if (cnt == NW'(NDIG - 1)) begin
                    bin_n   = acc_step;
                    done_n  = 1'b1;
                    state_n = ENTRY;
                end
            end

            default: state_n = ENTRY;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ENTRY;
            bcd     <= '0;
            ndigits <= '0;
            bin     <= '0;
            done    <= 1'b0;
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            bcd     <= bcd_n;
            ndigits <= ndigits_n;
            bin     <= bin_n;
            done    <= done_n;
            sr      <= sr_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
        end
    end

endmodule
